imem_loader: RTL and testbench

//  Boot loader upstream of the single-cycle RV32I core. Takes a byte stream over a

---
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader for the RV32I core's instruction memory.
// Accepts the frame A5, LEN_LO, LEN_HI, 4*N payload bytes, CSUM on a byte
// handshake. Payload bytes are packed little-endian into 32-bit words and written
// to the instruction memory. The core is held in reset until a frame has loaded
// with a matching XOR checksum.
module imem_loader #(
  parameter int DEPTH_WORDS    = 256,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_word_idx;   // one extra bit so N == DEPTH_WORDS cannot wrap
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_word;       // lower three lanes; the 4th byte goes straight out
  logic [7:0]        r_csum;
  logic [31:0]       r_idle_cnt;
  logic              r_cpu_rst;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;

  logic              w_xfer;
  logic              w_timed;
  logic              w_timeout;
  logic [15:0]       w_len;
  logic              w_len_bad;
  logic              w_last_word;

  assign in_ready   = (r_state != S_WRITE);
  assign w_xfer     = in_valid && in_ready;
  assign imem_we    = (r_state == S_WRITE);
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_rst    = r_cpu_rst;
  assign load_done  = (r_state == S_DONE);
  assign load_err   = (r_state == S_ERROR);

  assign w_len       = {in_data, r_len[7:0]};
  assign w_len_bad   = (w_len == 16'd0) || (32'(w_len) > 32'(DEPTH_WORDS));
  assign w_last_word = (32'(r_word_idx) == (32'(r_len) - 32'd1));

  assign w_timed   = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                     (r_state == S_DATA)   || (r_state == S_CSUM);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_timed && !w_xfer &&
                     (r_idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Next-state decode; a timeout overrides everything in the timed states.
  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = S_ERROR;
    end else begin
      case (r_state)
        S_IDLE:   if (w_xfer && in_data == SYNC_BYTE) w_state_next = S_LEN_LO;
        S_LEN_LO: if (w_xfer) w_state_next = S_LEN_HI;
        S_LEN_HI: if (w_xfer) w_state_next = w_len_bad ? S_ERROR : S_DATA;
        S_DATA:   if (w_xfer && r_byte_idx == 2'd3) w_state_next = S_WRITE;
        S_WRITE:  w_state_next = w_last_word ? S_CSUM : S_DATA;
        S_CSUM:   if (w_xfer) w_state_next = (in_data == r_csum) ? S_DONE : S_ERROR;
        S_DONE,
        S_ERROR:  if (w_xfer && in_data == SYNC_BYTE) w_state_next = S_LEN_LO;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // State, registered core reset and idle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cpu_rst  <= 1'b1;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      // Releases on the edge entering DONE, reasserts on the edge leaving it.
      r_cpu_rst  <= (w_state_next != S_DONE);
      if (w_timed && !w_xfer && !w_timeout)
        r_idle_cnt <= r_idle_cnt + 32'd1;
      else
        r_idle_cnt <= '0;
    end
  end

  // Frame datapath: length capture, word assembly, checksum and write port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len        <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_csum       <= '0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
    end else begin
      case (r_state)
        S_LEN_LO: if (w_xfer) r_len[7:0] <= in_data;
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= in_data;
            r_word_idx  <= '0;
            r_byte_idx  <= '0;
            r_csum      <= '0;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_csum     <= r_csum ^ in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_imem_addr  <= r_word_idx[ADDR_W-1:0];
              r_imem_wdata <= {in_data, r_word};
            end else begin
              r_word[{r_byte_idx, 3'b000} +: 8] <= in_data;
            end
          end
        end
        S_WRITE: r_word_idx <= r_word_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the stimulus side queues every expected
// memory write, and a monitor pops and compares on each imem_we strobe.
module tb_imem_loader;
  localparam int DEPTH  = 256;
  localparam int AW     = 8;
  localparam int TO     = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;

  int checks = 0;
  int failures = 0;
  logic [39:0] exp_q[$];
  logic [31:0] words[0:7];

  imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {imem_addr, imem_wdata}, 40'h0);
      end else begin
        chk("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
      end
    end
  end

  // Offer one byte from a negedge and hold it until accepted.
  task automatic send(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_stuck", {39'd0, in_ready}, 40'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Full frame from words[]; the checksum is computed here unless overridden.
  task automatic send_frame(input int n, input bit use_csum, input logic [7:0] csum_val);
    logic [7:0] cs;
    logic [31:0] w;
    cs = 8'h00;
    send(8'hA5);
    send(8'(n));
    send(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ w[8*k +: 8];
        if (k == 3) exp_q.push_back({8'(i), w});
        send(w[8*k +: 8]);
      end
      chk("we_after_4th_byte", {39'd0, imem_we}, 40'd1);
    end
    chk("cpu_rst_before_csum", {39'd0, cpu_rst}, 40'd1);
    send(use_csum ? csum_val : cs);
  endtask

  task automatic chk_status(input string tag, input logic r, input logic d, input logic e);
    chk({tag, "_cpu_rst"}, {39'd0, cpu_rst}, {39'd0, r});
    chk({tag, "_done"}, {39'd0, load_done}, {39'd0, d});
    chk({tag, "_err"}, {39'd0, load_err}, {39'd0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Reset state
    chk("rst_in_ready", {39'd0, in_ready}, 40'd1);
    chk("rst_we", {39'd0, imem_we}, 40'd0);
    chk("rst_addr_data", {imem_addr, imem_wdata}, 40'd0);
    chk_status("rst", 1'b1, 1'b0, 1'b0);

    // 1: two-word program; payload XOR = 13^93^10 = 0x90
    words[0] = 32'h00000013;
    words[1] = 32'h00100093;
    send_frame(2, 1'b0, 8'h00);
    chk_status("t1", 1'b0, 1'b1, 1'b0);

    // 5: sync in DONE reasserts cpu_rst immediately, then reload N=1
    send(8'hA5);
    chk_status("t5_sync", 1'b1, 1'b0, 1'b0);
    send(8'h01); send(8'h00);
    exp_q.push_back({8'd0, 32'hDEADBEEF});
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    send(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
    chk_status("t5", 1'b0, 1'b1, 1'b0);

    // 2: same two-word frame with a wrong checksum
    send_frame(2, 1'b1, 8'h00);
    chk_status("t2", 1'b1, 1'b0, 1'b1);

    // 3: illegal lengths, error right after LEN_HI
    send(8'hA5); send(8'h00);
    chk("t3a_before", {39'd0, load_err}, 40'd0);
    send(8'h00);
    chk_status("t3a", 1'b1, 1'b0, 1'b1);
    send(8'hA5); send(8'h01);
    chk("t3b_before", {39'd0, load_err}, 40'd0);
    send(8'h01);
    chk_status("t3b", 1'b1, 1'b0, 1'b1);

    // 4: stall mid-DATA; error on the 16th idle cycle, not the 15th
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    idle(TO - 1);
    chk("t4_idle15_err", {39'd0, load_err}, 40'd0);
    idle(1);
    chk_status("t4_timeout", 1'b1, 1'b0, 1'b1);
    words[0] = 32'h12345678;
    send_frame(1, 1'b0, 8'h00);
    chk_status("t4_reload", 1'b0, 1'b1, 1'b0);

    // 6: reset after 6 payload bytes, then garbage and a clean frame
    send(8'hA5); send(8'h02); send(8'h00);
    exp_q.push_back({8'd0, 32'h44332211});
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk_status("t6_rst", 1'b1, 1'b0, 1'b0);
    send(8'h55); send(8'h00); send(8'h5A);
    chk_status("t6_garbage", 1'b1, 1'b0, 1'b0);
    idle(20);
    words[0] = 32'hCAFEF00D;
    send_frame(1, 1'b0, 8'h00);
    chk_status("t6_reload", 1'b0, 1'b1, 1'b0);

    idle(5);
    chk("pending_writes", 40'(exp_q.size()), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
